// File: rtl/dac_bus_scheduler_pkg.sv
// Shared types and helpers for the DAC bus scheduler: FSM state encoding and
// an index-width helper that never returns zero.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLOSE = 2'd2
    } sched_state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dac_bus_scheduler_rr_arbiter.sv
// Combinational round-robin search: starts one past the last winner and
// returns the first requester with data; the pointer register lives in the parent.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NCH = 2,
    localparam int IW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    input  logic           fire,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           any
);

    logic [IW-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(ptr) + k) % NCH);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        gnt = (fire && any) ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/dac_bus_scheduler.sv
// Time-slotted scheduler sharing one serial DAC bus (sclk/sdi) among NCH
// AXI-stream sample sources, each driving its own chip select.
module dac_bus_scheduler
    import dac_sched_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NCH  = 2,
    parameter int SLOT = 48,
    localparam int GW  = clog2_min1(NCH)
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              en,
    input  logic [NCH-1:0]    s_axis_tvalid,
    output logic [NCH-1:0]    s_axis_tready,
    input  logic [NCH*DW-1:0] s_axis_tdata,
    output logic              sclk,
    output logic              sdi,
    output logic [NCH-1:0]    cs_n,
    output logic [GW-1:0]     grant,
    output logic              slot_idle,
    output logic              frame_done
);

    localparam int CW = $clog2(SLOT);
    localparam int PW = $clog2(2 * DW);

    if (SLOT < 2 * DW + 3) begin : g_slot_chk
        $error("SLOT must cover a full frame plus close: SLOT >= 2*DW+3");
    end
    if (NCH < 2 || NCH > 8) begin : g_nch_chk
        $error("NCH must be in 2..8");
    end

    sched_state_t  state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ph;
    logic [GW-1:0] ptr;
    logic [DW-1:0] shreg;
    logic [GW-1:0] idx;
    logic          any;
    logic          tick;
    logic [DW-1:0] word;

    // Gated by reset so nothing handshakes while the block is held in reset.
    assign tick      = s_axis_aresetn && en && (cnt == '0) && (state == IDLE);
    assign slot_idle = tick && !any;
    assign word      = s_axis_tdata[idx*DW +: DW];

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req  (s_axis_tvalid),
        .ptr  (ptr),
        .fire (tick),
        .gnt  (s_axis_tready),
        .idx  (idx),
        .any  (any)
    );

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state      <= IDLE;
            cnt        <= '0;
            ph         <= '0;
            ptr        <= GW'(NCH - 1);
            grant      <= '0;
            sclk       <= 1'b0;
            sdi        <= 1'b0;
            cs_n       <= '1;
            frame_done <= 1'b0;
        end else if (en) begin
            cnt        <= (cnt == CW'(SLOT - 1)) ? '0 : cnt + CW'(1);
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && any) begin
                        shreg <= word;
                        ptr   <= idx;
                        grant <= idx;
                        cs_n  <= ~(NCH'(1) << idx);
                        sdi   <= word[DW-1];
                        sclk  <= 1'b0;
                        ph    <= '0;
                        state <= SHIFT;
                    end
                end
                // Even phase = sclk low (data set up), odd phase = sclk high.
                SHIFT: begin
                    ph <= ph + PW'(1);
                    if (!ph[0]) begin
                        sclk <= 1'b1;
                    end else if (ph == PW'(2 * DW - 1)) begin
                        sclk  <= 1'b0;
                        state <= CLOSE;
                    end else begin
                        sclk  <= 1'b0;
                        sdi   <= shreg[DW-2];
                        shreg <= shreg << 1;
                    end
                end
                CLOSE: begin
                    cs_n       <= '1;
                    frame_done <= 1'b1;
                    ph         <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_bus_scheduler.sv
// Scoreboard bench for dac_bus_scheduler: per-chip-select shift-in DAC models
// check frames against expectations queued by the directed stimulus.
module tb_dac_bus_scheduler;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        en;
    logic        rstn_a, rstn_b;

    // NCH=2 instance
    logic [1:0]  a_tvalid, a_tready, a_cs_n;
    logic [31:0] a_tdata;
    logic        a_sclk, a_sdi, a_slot_idle, a_frame_done;
    logic [0:0]  a_grant;
    logic [15:0] dat_a [2];
    int          tgt_a [2];
    int          hs_a  [2];
    int          hs_t_a[2][$];

    // NCH=4 instance
    logic [3:0]  b_tvalid, b_tready, b_cs_n;
    logic [63:0] b_tdata;
    logic        b_sclk, b_sdi, b_slot_idle, b_frame_done;
    logic [1:0]  b_grant;
    logic [15:0] dat_b [4];
    int          tgt_b [4];
    int          hs_b  [4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t q_a[$];
    int   q_b[$];

    dac_bus_scheduler #(.DW(16), .NCH(2), .SLOT(48)) dut_a (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rstn_a),
        .en             (en),
        .s_axis_tvalid  (a_tvalid),
        .s_axis_tready  (a_tready),
        .s_axis_tdata   (a_tdata),
        .sclk           (a_sclk),
        .sdi            (a_sdi),
        .cs_n           (a_cs_n),
        .grant          (a_grant),
        .slot_idle      (a_slot_idle),
        .frame_done     (a_frame_done)
    );

    dac_bus_scheduler #(.DW(16), .NCH(4), .SLOT(48)) dut_b (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rstn_b),
        .en             (1'b1),
        .s_axis_tvalid  (b_tvalid),
        .s_axis_tready  (b_tready),
        .s_axis_tdata   (b_tdata),
        .sclk           (b_sclk),
        .sdi            (b_sdi),
        .cs_n           (b_cs_n),
        .grant          (b_grant),
        .slot_idle      (b_slot_idle),
        .frame_done     (b_frame_done)
    );

    // Sources: each holds tvalid until its word quota has been accepted.
    always_comb begin
        a_tvalid = '0;
        b_tvalid = '0;
        for (int i = 0; i < 2; i++) a_tvalid[i] = (tgt_a[i] > hs_a[i]);
        for (int i = 0; i < 4; i++) b_tvalid[i] = (tgt_b[i] > hs_b[i]);
        a_tdata = {dat_a[1], dat_a[0]};
        b_tdata = {dat_b[3], dat_b[2], dat_b[1], dat_b[0]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (a_tvalid[i] && a_tready[i]) begin
                hs_a[i] <= hs_a[i] + 1;
                hs_t_a[i].push_back(cyc);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (b_tvalid[i] && b_tready[i]) hs_b[i] <= hs_b[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // DAC models for instance A, one per chip select.
    logic [1:0]  prev_cs = 2'b11;
    logic        prev_sclk = 1'b0;
    logic [15:0] sh [2];
    logic [15:0] latched [2];
    int          bits [2];
    int          lowl [2];
    int          n_fall [2];
    int          n_abort = 0;
    bit          allow_abort = 0;
    exp_t        e;

    initial begin
        for (int i = 0; i < 2; i++) begin
            sh[i] = '0; latched[i] = '0; bits[i] = 0; lowl[i] = 0; n_fall[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!a_cs_n[i]) begin
                if (prev_cs[i]) begin
                    lowl[i] = 0; bits[i] = 0; sh[i] = '0; n_fall[i]++;
                end
                lowl[i]++;
                if (a_sclk && !prev_sclk) begin
                    sh[i] = {sh[i][14:0], a_sdi};
                    bits[i]++;
                end
            end else if (!prev_cs[i]) begin
                if (bits[i] != 16 && allow_abort) begin
                    n_abort++;
                end else if (bits[i] != 16) begin
                    chk("frame_bits", bits[i], 16);
                end else begin
                    latched[i] = sh[i];
                    if (q_a.size() == 0) begin
                        chk("unexpected_frame_ch", i, 32'hFFFF_FFFF);
                    end else begin
                        e = q_a.pop_front();
                        chk("frame_ch", i, e.ch);
                        chk("frame_data", sh[i], e.data);
                        chk("frame_cs_low_len", lowl[i], e.len);
                        chk("frame_done_pulse", a_frame_done, 1);
                        chk("frame_grant", a_grant, i);
                    end
                end
            end
        end
        chk("tready_onehot0", $onehot0(a_tready), 1);
        chk("cs_n_onehot0", $onehot0(~a_cs_n), 1);
        if (&a_cs_n) chk("sclk_low_outside_frame", a_sclk, 0);
        prev_cs   = a_cs_n;
        prev_sclk = a_sclk;
    end

    // Bus model for instance B: captures whichever DAC is selected.
    logic [15:0] sh_b = '0;
    int          bits_b = 0;
    logic        prev_sclk_b = 1'b0;
    int          g;

    always @(negedge clk) begin
        if (b_cs_n != 4'hF && b_sclk && !prev_sclk_b) begin
            sh_b = {sh_b[14:0], b_sdi};
            bits_b++;
        end
        if (b_frame_done) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_frame_grant", b_grant, 32'hFFFF_FFFF);
            end else begin
                g = q_b.pop_front();
                chk("b_grant_order", b_grant, g);
                chk("b_data", sh_b, dat_b[g]);
                chk("b_bits", bits_b, 16);
            end
            sh_b = '0;
            bits_b = 0;
        end
        prev_sclk_b = b_sclk;
    end

    task automatic give(input int ch, input int n);
        tgt_a[ch] = hs_a[ch] + n;
    endtask

    task automatic push_a(input int ch, input logic [15:0] d, input int len);
        exp_t x;
        x.ch = ch; x.data = d; x.len = len;
        q_a.push_back(x);
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = (q_a.size() == 0) && (tgt_a[0] <= hs_a[0]) && (tgt_a[1] <= hs_a[1]);
        end
        chk(name, done, 1);
    endtask

    task automatic wait_hs(input string name, input int ch, input int budget);
        int h0;
        bit seen;
        h0 = hs_a[ch];
        seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = (hs_a[ch] != h0);
        end
        chk(name, seen, 1);
    endtask

    logic [8:0] snap;
    int         idles;
    int         falls0;
    bit         hit;

    initial begin
        en = 1'b1;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        for (int i = 0; i < 2; i++) begin tgt_a[i] = 0; hs_a[i] = 0; dat_a[i] = '0; end
        for (int i = 0; i < 4; i++) begin tgt_b[i] = 0; hs_b[i] = 0; end
        dat_b[0] = 16'h1111; dat_b[1] = 16'h2222; dat_b[2] = 16'h3333; dat_b[3] = 16'h4444;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", a_cs_n, 2'b11);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_sdi", a_sdi, 0);
        chk("rst_tready", a_tready, 0);
        chk("rst_grant", a_grant, 0);
        chk("rst_pulses", {a_frame_done, a_slot_idle}, 0);

        // Test 1 (and concurrently test 6 on the 4-channel instance)
        dat_a[0] = 16'hA5C3;
        for (int k = 0; k < 3; k++) push_a(0, 16'hA5C3, 33);
        give(0, 3);
        tgt_b[0] = 2; tgt_b[1] = 2; tgt_b[2] = 0; tgt_b[3] = 2;
        for (int k = 0; k < 2; k++) begin q_b.push_back(0); q_b.push_back(1); q_b.push_back(3); end
        @(posedge clk); #1 rstn_a = 1'b1; rstn_b = 1'b1;
        drain("t1_drain", 400);
        chk("t1_gap01", hs_t_a[0][1] - hs_t_a[0][0], 48);
        chk("t1_gap12", hs_t_a[0][2] - hs_t_a[0][1], 48);
        chk("t1_cs1_never_low", n_fall[1], 0);

        // Test 2: both valid, alternating service
        @(negedge clk); rstn_a = 1'b0;
        repeat (2) @(posedge clk);
        dat_a[0] = 16'h1234; dat_a[1] = 16'hFEDC;
        hs_t_a[0].delete(); hs_t_a[1].delete();
        for (int k = 0; k < 2; k++) begin push_a(0, 16'h1234, 33); push_a(1, 16'hFEDC, 33); end
        give(0, 2); give(1, 2);
        #1 rstn_a = 1'b1;
        drain("t2_drain", 500);
        chk("t2_tready0_period", hs_t_a[0][1] - hs_t_a[0][0], 96);
        chk("t2_tready1_period", hs_t_a[1][1] - hs_t_a[1][0], 96);
        chk("t2_interleave", hs_t_a[1][0] - hs_t_a[0][0], 48);

        // Test 3: idle slots, then requester 1, then pointer retention
        @(negedge clk); rstn_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_a = 1'b1;
        idles = 0;
        falls0 = n_fall[0] + n_fall[1];
        for (int n = 0; n < 96; n++) begin
            @(negedge clk);
            if (a_slot_idle) idles++;
        end
        chk("t3_idle_pulses", idles, 2);
        chk("t3_no_cs_fall", n_fall[0] + n_fall[1] - falls0, 0);
        dat_a[1] = 16'h0F0F;
        push_a(1, 16'h0F0F, 33);
        give(1, 1);
        drain("t3_drain_ch1", 200);
        idles = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (a_slot_idle) idles++;
        end
        chk("t3_idle_after_ch1", idles, 1);
        dat_a[0] = 16'h3C3C;
        push_a(0, 16'h3C3C, 33);
        push_a(1, 16'h0F0F, 33);
        give(0, 1); give(1, 1);
        drain("t3_drain_ptr", 300);

        // Test 4: reset during bit 7 of a frame
        dat_a[1] = 16'h6996;
        give(1, 1);
        wait_hs("t4_handshake", 1, 120);
        allow_abort = 1;
        hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            hit = (bits[1] == 7);
        end
        chk("t4_reached_bit7", hit, 1);
        rstn_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_cs_n_abort", a_cs_n, 2'b11);
        chk("t4_sclk_abort", a_sclk, 0);
        chk("t4_grant_reset", a_grant, 0);
        @(negedge clk);
        chk("t4_no_partial_latch", latched[1], 16'h0F0F);
        chk("t4_abort_seen", n_abort, 1);
        allow_abort = 0;
        dat_a[0] = 16'hC00C; dat_a[1] = 16'h0660;
        push_a(0, 16'hC00C, 33);
        push_a(1, 16'h0660, 33);
        give(0, 1); give(1, 1);
        @(posedge clk); #1 rstn_a = 1'b1;
        drain("t4_drain", 300);

        // Test 5: clock enable low for 5 cycles mid-frame
        dat_a[0] = 16'h8001;
        push_a(0, 16'h8001, 38);
        give(0, 1);
        wait_hs("t5_handshake", 0, 120);
        repeat (10) @(negedge clk);
        snap = {a_sclk, a_sdi, a_cs_n, a_grant, a_frame_done, a_slot_idle, a_tready};
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("t5_hold", {a_sclk, a_sdi, a_cs_n, a_grant, a_frame_done, a_slot_idle, a_tready}, snap);
        end
        en = 1'b1;
        drain("t5_drain", 200);

        // Test 6 completion on the 4-channel instance
        hit = 0;
        for (int n = 0; n < 600 && !hit; n++) begin
            @(negedge clk);
            hit = (q_b.size() == 0);
        end
        chk("t6_all_frames", hit, 1);
        chk("t6_req2_unserved", hs_b[2], 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
